// File: rtl/gray_monitor.sv
// rtl/gray_monitor.sv - Gray code sequence monitor: decodes, checks +1 steps, counts, flags wrap and faults
module gray_monitor #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Gray_In,
    input  logic             Valid,
    input  logic             Resync,
    output logic [WIDTH-1:0] Binary,
    output logic [CNT_W-1:0] Step_Count,
    output logic             Wrap,
    output logic             Locked,
    output logic             Error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] prev_q, prev_n;
    logic [WIDTH-1:0] binary_q, binary_n;
    logic [CNT_W-1:0] step_q, step_n;
    logic             wrap_q, wrap_n;
    logic             locked_q, locked_n;
    logic             error_q, error_n;

    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] prev_inc;
    logic [CNT_W-1:0] step_inc;

    // Each binary bit is the XOR of its Gray bit and every bit above it.
    always_comb begin
        dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec[i] = ^(Gray_In >> i);
        end
    end

    assign prev_inc = prev_q + 1'b1;
    assign step_inc = (step_q == {CNT_W{1'b1}}) ? step_q : step_q + 1'b1;

    always_comb begin
        state_n  = state_q;
        prev_n   = prev_q;
        binary_n = binary_q;
        step_n   = step_q;
        wrap_n   = 1'b0;
        locked_n = locked_q;
        error_n  = error_q;

        if (Resync) begin
            // Re-acquire: outputs that describe history (Binary, count) are kept.
            state_n  = IDLE;
            locked_n = 1'b0;
            error_n  = 1'b0;
        end else if (Valid) begin
            case (state_q)
                IDLE: begin
                    prev_n   = dec;
                    binary_n = dec;
                    locked_n = 1'b1;
                    state_n  = TRACK;
                end
                TRACK: begin
                    if (dec == prev_q) begin
                        state_n = TRACK;
                    end else if (dec == prev_inc) begin
                        prev_n   = dec;
                        binary_n = dec;
                        step_n   = step_inc;
                        wrap_n   = (prev_q == {WIDTH{1'b1}});
                    end else begin
                        prev_n   = dec;
                        binary_n = dec;
                        error_n  = 1'b1;
                        locked_n = 1'b0;
                        state_n  = FAULT;
                    end
                end
                FAULT: begin
                    prev_n   = dec;
                    binary_n = dec;
                end
                default: begin
                    state_n  = IDLE;
                    locked_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            binary_q <= '0;
            step_q   <= '0;
            wrap_q   <= 1'b0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            prev_q   <= prev_n;
            binary_q <= binary_n;
            step_q   <= step_n;
            wrap_q   <= wrap_n;
            locked_q <= locked_n;
            error_q  <= error_n;
        end
    end

    assign Binary     = binary_q;
    assign Step_Count = step_q;
    assign Wrap       = wrap_q;
    assign Locked     = locked_q;
    assign Error      = error_q;

endmodule

// File: tb/tb_gray_monitor.sv
// tb/tb_gray_monitor.sv - table-driven scoreboard bench for gray_monitor
module tb_gray_monitor;

    localparam int WIDTH = 3;
    localparam int CNT_W = 4;

    logic             Clk;
    logic             Reset;
    logic [WIDTH-1:0] Gray_In;
    logic             Valid;
    logic             Resync;
    logic [WIDTH-1:0] Binary;
    logic [CNT_W-1:0] Step_Count;
    logic             Wrap;
    logic             Locked;
    logic             Error;

    gray_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Gray_In    (Gray_In),
        .Valid      (Valid),
        .Resync     (Resync),
        .Binary     (Binary),
        .Step_Count (Step_Count),
        .Wrap       (Wrap),
        .Locked     (Locked),
        .Error      (Error)
    );

    typedef struct {
        logic [WIDTH-1:0] bin;
        logic [CNT_W-1:0] step;
        logic             wrap;
        logic             lock;
        logic             err;
    } exp_t;

    typedef struct {
        logic             rst;
        logic             vld;
        logic             rsy;
        logic [WIDTH-1:0] g;
        exp_t             ex;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_idx  = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic void add(input logic rst, input logic vld, input logic rsy,
                                input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] b,
                                input logic [CNT_W-1:0] s, input logic w,
                                input logic l, input logic e);
        vec_t v;
        v.rst = rst; v.vld = vld; v.rsy = rsy; v.g = g;
        v.ex.bin = b; v.ex.step = s; v.ex.wrap = w; v.ex.lock = l; v.ex.err = e;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, vec_idx, act, req);
        end
    endtask

    task automatic apply(input logic rst, input logic vld, input logic rsy,
                         input logic [WIDTH-1:0] g, input exp_t ex);
        @(negedge Clk);
        Reset   = rst;
        Valid   = vld;
        Resync  = rsy;
        Gray_In = g;
        sb.push_back(ex);
    endtask

    // Outputs settle on the rising edge; sample them shortly after.
    always @(posedge Clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vec_idx++;
            chk("binary", 32'(Binary), 32'(e.bin));
            chk("step_count", 32'(Step_Count), 32'(e.step));
            chk("wrap", 32'(Wrap), 32'(e.wrap));
            chk("locked", 32'(Locked), 32'(e.lock));
            chk("error", 32'(Error), 32'(e.err));
        end
    end

    initial begin
        exp_t ex;
        Reset = 1'b1; Valid = 1'b0; Resync = 1'b0; Gray_In = '0;

        //  rst vld rsy gray    bin   step  w  l  e
        add(1, 1, 0, 3'b101, 3'd0, 4'd0, 0, 0, 0);
        add(1, 1, 0, 3'b101, 3'd0, 4'd0, 0, 0, 0);
        add(0, 1, 0, 3'b000, 3'd0, 4'd0, 0, 1, 0);
        add(0, 1, 0, 3'b001, 3'd1, 4'd1, 0, 1, 0);
        add(0, 1, 0, 3'b011, 3'd2, 4'd2, 0, 1, 0);
        add(0, 1, 0, 3'b010, 3'd3, 4'd3, 0, 1, 0);
        add(0, 1, 0, 3'b110, 3'd4, 4'd4, 0, 1, 0);
        add(0, 1, 0, 3'b111, 3'd5, 4'd5, 0, 1, 0);
        add(0, 1, 0, 3'b101, 3'd6, 4'd6, 0, 1, 0);
        add(0, 1, 0, 3'b100, 3'd7, 4'd7, 0, 1, 0);
        add(0, 1, 0, 3'b000, 3'd0, 4'd8, 1, 1, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 3'($urandom_range(0, 7)), 3'd0, 4'd8, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 3'b000, 3'd0, 4'd8, 0, 1, 0);
        add(0, 1, 0, 3'b001, 3'd1, 4'd9, 0, 1, 0);
        add(0, 1, 0, 3'b010, 3'd3, 4'd9, 0, 0, 1);
        add(0, 1, 0, 3'b110, 3'd4, 4'd9, 0, 0, 1);
        add(0, 1, 0, 3'b111, 3'd5, 4'd9, 0, 0, 1);
        add(0, 1, 1, 3'b000, 3'd5, 4'd9, 0, 0, 0);
        add(0, 1, 0, 3'b110, 3'd4, 4'd9, 0, 1, 0);
        add(0, 1, 0, 3'b111, 3'd5, 4'd10, 0, 1, 0);
        add(1, 0, 0, 3'b000, 3'd0, 4'd0, 0, 0, 0);
        add(0, 1, 0, 3'b011, 3'd2, 4'd0, 0, 1, 0);
        add(0, 1, 0, 3'b010, 3'd3, 4'd1, 0, 1, 0);
        add(0, 0, 1, 3'b111, 3'd3, 4'd1, 0, 0, 0);
        add(0, 1, 0, 3'b111, 3'd5, 4'd1, 0, 1, 0);

        foreach (tbl[k]) apply(tbl[k].rst, tbl[k].vld, tbl[k].rsy, tbl[k].g, tbl[k].ex);

        // Run the count past 2^CNT_W-1 to exercise saturation and repeated wraps.
        ex = '{bin: '0, step: '0, wrap: 1'b0, lock: 1'b0, err: 1'b0};
        apply(1, 0, 0, 3'b000, ex);
        for (int i = 0; i <= 20; i++) begin
            logic [WIDTH-1:0] b;
            b = 3'(i % 8);
            ex.bin  = b;
            ex.step = (i > 15) ? 4'd15 : 4'(i);
            ex.wrap = (i > 0) && (i % 8 == 0);
            ex.lock = 1'b1;
            ex.err  = 1'b0;
            apply(0, 1, 0, b ^ (b >> 1), ex);
        end

        @(negedge Clk);
        Valid = 1'b0;
        for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge Clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_monitor.md
Name: gray_monitor

Overview:
Receiving end of the gray counter's output bus. Samples a WIDTH-bit Gray code word on each qualified clock and decodes it to binary. Checks that every accepted new word is exactly the next code in sequence, counts legal steps, and pulses on wrap-around (the receiver-side mirror of the counter's Overflow). Sits beside the gray counter in the test/debug path and flags any corrupted or skipped code.

Parameters:
WIDTH, 3, Gray/binary word width
CNT_W, 16, width of the step counter

Ports:
Clk  input  1  system clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
Gray_In  input  WIDTH  Gray code word from the counter
Valid  input  1  sample Gray_In on this edge (tied to counter En)
Resync  input  1  synchronous re-acquire request (tied to counter Reset)
Binary  output  WIDTH  registered binary decode of last accepted sample
Step_Count  output  CNT_W  number of legal +1 steps since Reset
Wrap  output  1  one-cycle pulse on legal step from 2^WIDTH-1 to 0
Locked  output  1  1 while tracking a valid sequence
Error  output  1  sticky sequence-violation flag

Behaviour:
- Reset (sync, highest priority): state=IDLE, Binary=0, Step_Count=0, Wrap=0, Locked=0, Error=0, prev=0.
- Decode: bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1] XOR g[i]. Combinational decode, registered output.
- Latency: Binary, Step_Count, Wrap, Locked, Error all update on the same edge that samples Gray_In (Valid=1); visible the cycle after Valid.
- Valid=0: all registers hold, except Wrap, which returns to 0. Gray_In is ignored.
- Wrap defaults to 0 every cycle unless set by a legal wrap step.
- States:
  - IDLE: Valid=1 -> prev=decode, Binary=decode, Locked=1, go TRACK. No check, no count.
  - TRACK, Valid=1, decoded value d:
    - d==prev: hold; no count, no error.
    - d==(prev+1) mod 2^WIDTH: prev=d, Binary=d, Step_Count+1 (saturating at 2^CNT_W-1).
      - If prev==2^WIDTH-1 and d==0, also Wrap=1 for one cycle.
    - Any other d: Binary=d, prev=d, Error=1, Locked=0, go FAULT.
  - FAULT: Error stays 1, Locked stays 0. Binary/prev keep following valid samples. No counting, no Wrap. Leaves only on Reset or Resync.
- Resync=1 (priority below Reset, above Valid):
  - state=IDLE, Locked=0, Error=0, Wrap=0.
  - Binary and Step_Count hold.
  - Valid on the same edge is ignored.
  - Next Valid after Resync deasserts re-acquires.
- Reset mid-sequence: all outputs zero next cycle; a valid sample after Reset is an IDLE acquire (no error even if not 0).
- Step_Count saturates; it never wraps to 0.

Test Plan:
1. WIDTH=3. Assert Reset 2 cycles with Gray_In=101, Valid=1 -> Binary=0, Step_Count=0, Wrap=0, Locked=0, Error=0.
2. From IDLE, Valid=1 each cycle, Gray_In=000,001,011,010,110,111,101,100 -> Binary=0..7 each one cycle late, Locked=1 after first, Step_Count=7, Error=0, Wrap=0.
3. Continue Gray_In=000 -> Binary=0, Step_Count=8, Wrap=1 for exactly one cycle then 0.
4. Valid=0 while Gray_In toggles random values for 5 cycles -> no output changes. Then Valid=1 with same word repeated 3 cycles -> Step_Count unchanged.
5. In TRACK at 001, apply 010 (binary 1->3) -> Error=1, Locked=0, Binary=3. Then 110, 111 (legal steps) -> Error stays 1, Step_Count frozen.
6. From FAULT, Resync=1 one cycle with Valid=1 -> Error=0, Locked=0, Binary held. Then Gray_In=110 with Valid=1 -> Locked=1, Binary=4, Step_Count unchanged. Then 111 -> Step_Count+1.
